// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions used by the display decoder and the capture block.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [6:0] SSEG_0     = 7'b1000000;
    localparam logic [6:0] SSEG_1     = 7'b1111001;
    localparam logic [6:0] SSEG_2     = 7'b0100100;
    localparam logic [6:0] SSEG_3     = 7'b0110000;
    localparam logic [6:0] SSEG_4     = 7'b0011001;
    localparam logic [6:0] SSEG_5     = 7'b0010010;
    localparam logic [6:0] SSEG_6     = 7'b0000010;
    localparam logic [6:0] SSEG_7     = 7'b1111000;
    localparam logic [6:0] SSEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_9     = 7'b0010000;
    localparam logic [6:0] SSEG_A     = 7'b0001000;
    localparam logic [6:0] SSEG_B     = 7'b0000011;
    localparam logic [6:0] SSEG_C     = 7'b1000110;
    localparam logic [6:0] SSEG_D     = 7'b0100001;
    localparam logic [6:0] SSEG_E     = 7'b0000110;
    localparam logic [6:0] SSEG_F     = 7'b0001110;
    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_pattern_to_hex.sv
// Combinational inverse of the display decoder: segment pattern -> {legal, nibble}.
// Any pattern outside the 16 hex glyphs reports legal_o=0 with nibble 0.
module sseg_pattern_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] sseg_i,
    output logic       legal_o,
    output logic [3:0] nibble_o
);

    // Table lookup over the shared glyph constants.
    always_comb begin
        legal_o  = 1'b1;
        nibble_o = 4'h0;
        case (sseg_i)
            SSEG_0:  nibble_o = 4'h0;
            SSEG_1:  nibble_o = 4'h1;
            SSEG_2:  nibble_o = 4'h2;
            SSEG_3:  nibble_o = 4'h3;
            SSEG_4:  nibble_o = 4'h4;
            SSEG_5:  nibble_o = 4'h5;
            SSEG_6:  nibble_o = 4'h6;
            SSEG_7:  nibble_o = 4'h7;
            SSEG_8:  nibble_o = 4'h8;
            SSEG_9:  nibble_o = 4'h9;
            SSEG_A:  nibble_o = 4'hA;
            SSEG_B:  nibble_o = 4'hB;
            SSEG_C:  nibble_o = 4'hC;
            SSEG_D:  nibble_o = 4'hD;
            SSEG_E:  nibble_o = 4'hE;
            SSEG_F:  nibble_o = 4'hF;
            default: begin
                legal_o  = 1'b0;
                nibble_o = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/sseg_capture.sv
// Samples an external multiplexed seven-segment display and rebuilds the shown hex word.
// A digit is accepted once its {an,sseg} has been stable for STABLE_CYCLES samples with
// exactly one anode low; a frame is emitted the cycle after every slot has been seen.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              sseg,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic                    frame_err
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]              sseg_s1_q, sseg_s2_q, sseg_prev_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] slots_q;
    logic [NUM_DIGITS-1:0]   seen_q, err_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic                    value_valid_q, frame_err_q;

    logic                    same;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    one_hot;
    logic                    accept;
    logic                    frame_done;
    logic                    pat_legal;
    logic [3:0]              pat_nibble;

    sseg_pattern_to_hex u_decode (
        .sseg_i   (sseg_s2_q),
        .legal_o  (pat_legal),
        .nibble_o (pat_nibble)
    );

    assign same       = ({an_s2_q, sseg_s2_q} == {an_prev_q, sseg_prev_q});
    assign an_low     = ~an_s2_q;
    assign one_hot    = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    // Fires only on the transition into saturation, so one accept per dwell.
    assign accept     = same && (cnt_q == CNT_MAX - CW'(1)) && one_hot;
    assign frame_done = &seen_q;

    // Stability counter: restart on any change, saturate at the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Two-flop synchronizer plus previous-sample register; blank (all-ones) on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_s1_q     <= '1;
            an_s2_q     <= '1;
            an_prev_q   <= '1;
            sseg_s1_q   <= SSEG_BLANK;
            sseg_s2_q   <= SSEG_BLANK;
            sseg_prev_q <= SSEG_BLANK;
            cnt_q       <= '0;
        end else begin
            an_s1_q     <= an;
            an_s2_q     <= an_s1_q;
            an_prev_q   <= an_s2_q;
            sseg_s1_q   <= sseg;
            sseg_s2_q   <= sseg_s1_q;
            sseg_prev_q <= sseg_s2_q;
            cnt_q       <= cnt_d;
        end
    end

    // Slot capture; a frame-complete cycle clears seen/err unless that slot is re-accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            slots_q <= '0;
            seen_q  <= '0;
            err_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (accept && an_low[k]) begin
                    slots_q[4*k +: 4] <= pat_nibble;
                    seen_q[k]         <= 1'b1;
                    err_q[k]          <= ~pat_legal;
                end else if (frame_done) begin
                    seen_q[k] <= 1'b0;
                    err_q[k]  <= 1'b0;
                end
            end
        end
    end

    // Registered frame output: value holds between frames, valid is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= '0;
            value_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            value_valid_q <= frame_done;
            if (frame_done) begin
                value_q     <= slots_q;
                frame_err_q <= |err_q;
            end
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: drives multiplexed display scans, expected frames go into a
// queue and a negedge monitor pops and compares on every value_valid pulse.
module tb_sseg_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [15:0] value;
    logic        value_valid;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

    // {frame_err, value}
    logic [16:0] exp_q[$];
    logic        mon_en     = 1'b0;
    logic        prev_valid = 1'b0;

    logic [6:0] code_tbl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .sseg        (sseg),
        .value       (value),
        .value_valid (value_valid),
        .frame_err   (frame_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every valid pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (value_valid === 1'b1) begin
                check("valid_single_pulse", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got value %0h err %0b with nothing expected at %0t",
                             value, frame_err, $time);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("frame_value", {16'd0, value}, {16'd0, e[15:0]});
                    check("frame_err", {31'd0, frame_err}, {31'd0, e[16]});
                end
            end
            prev_valid = (value_valid === 1'b1);
        end
    end

    // Drivers
    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(4'hF, 7'h7F, n);
    endtask

    task automatic digit(input int k, input int v);
        logic [3:0] a;
        a    = 4'hF;
        a[k] = 1'b0;
        show(a, code_tbl[v], 20);
    endtask

    task automatic scan4(input int v3, input int v2, input int v1, input int v0);
        digit(0, v0);
        digit(1, v1);
        digit(2, v2);
        digit(3, v3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            an   = 4'($urandom_range(0, 15));
            sseg = 7'($urandom_range(0, 127));
            @(negedge clk);
            check("reset_value", {16'd0, value}, 32'd0);
            check("reset_valid", {31'd0, value_valid}, 32'd0);
            check("reset_err", {31'd0, frame_err}, 32'd0);
        end
        reset = 1'b0;
        an    = 4'hF;
        sseg  = 7'h7F;
    endtask

    initial begin
        reset = 1'b1;
        an    = 4'hF;
        sseg  = 7'h7F;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        blank(5);

        // Normal frame
        exp_q.push_back({1'b0, 16'h4321});
        scan4(4, 3, 2, 1);
        blank(30);
        check("value_hold", {16'd0, value}, 32'h4321);

        // Glitch: short digit-0 pattern as the last dwell must not complete the frame
        exp_q.push_back({1'b0, 16'h4321});
        digit(1, 2);
        digit(2, 3);
        digit(3, 4);
        show(4'b1110, code_tbl[8], 10);
        digit(0, 1);
        blank(10);

        // Invalid pattern on digit 2
        exp_q.push_back({1'b1, 16'hF05A});
        digit(0, 10);
        digit(1, 5);
        show(4'b1011, 7'h7F, 20);
        digit(3, 15);
        blank(10);

        // Bad anode dwells between digits
        exp_q.push_back({1'b0, 16'h8C7E});
        digit(0, 14);
        show(4'b1100, code_tbl[0], 40);
        digit(1, 7);
        show(4'b1111, code_tbl[0], 40);
        digit(2, 12);
        show(4'b1100, code_tbl[0], 40);
        digit(3, 8);
        blank(10);

        // Reset mid-frame discards digits 0,1
        digit(0, 9);
        digit(1, 11);
        do_reset();
        digit(2, 13);
        digit(3, 6);
        blank(10);
        check("value_after_reset", {16'd0, value}, 32'd0);
        exp_q.push_back({1'b0, 16'h6DB9});
        scan4(6, 13, 11, 9);
        blank(10);

        blank(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
